// File: rtl/seg7_scanner.sv
// seg7_scanner
// Multiplexed 7-segment display driver with a parameterised number of digits.
// Hex data, decimal points and the leading-zero-blank enable are copied into
// shadow registers once per frame, so a value never tears mid-scan.
// Brightness PWM, per-digit blink and the master enable act live.
//
// Ports
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_data       : packed hex digits, digit k = i_data[4k+3:4k], digit 0 rightmost
//   i_dots       : decimal point per digit
//   i_lz_blank   : enable leading-zero blanking
//   i_bright     : brightness, duty = (i_bright+1)/16
//   i_blink      : per-digit blink mask
//   i_en         : 0 = whole display dark
//   o_anodes     : one-hot anode select (registered, polarity by parameter)
//   o_segments   : {A,B,C,D,E,F,G,P} (registered, polarity by parameter)
//   o_frame      : one-cycle pulse in the first output cycle of each frame

module seg7_scanner #(
    parameter int DIGITS           = 4,
    parameter int CNT_WIDTH        = 14,
    parameter int BLINK_WIDTH      = 5,
    parameter int ANODE_ACTIVE_LOW = 1,
    parameter int SEG_ACTIVE_LOW   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [4*DIGITS-1:0] i_data,
    input  logic [DIGITS-1:0]   i_dots,
    input  logic                i_lz_blank,
    input  logic [3:0]          i_bright,
    input  logic [DIGITS-1:0]   i_blink,
    input  logic                i_en,
    output logic [DIGITS-1:0]   o_anodes,
    output logic [7:0]          o_segments,
    output logic                o_frame
);

    localparam int IDX_W = $clog2(DIGITS);
    localparam logic [DIGITS-1:0] ANODE_INV =
        (ANODE_ACTIVE_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};
    localparam logic [7:0] SEG_INV = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;

    logic [CNT_WIDTH-1:0]   dwell_q, dwell_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [BLINK_WIDTH-1:0] fcnt_q, fcnt_d;
    logic [4*DIGITS-1:0]    shData_q, shData_d;
    logic [DIGITS-1:0]      shDots_q, shDots_d;
    logic                   shLz_q, shLz_d;
    logic                   frameHit_q, frameHit_d;
    logic [DIGITS-1:0]      anodes_q, anodes_d;
    logic [7:0]             segments_q, segments_d;
    logic                   frame_q, frame_d;

    logic                   dwellEnd;
    logic                   lastDigit;
    logic                   boundary;

    logic [3:0]             curNib;
    logic                   curDot;
    logic                   curBlink;
    logic                   curLzBlank;
    logic [DIGITS-1:0]      oneHot;
    logic [DIGITS-1:0]      lzMask;
    logic                   allZero;
    logic [6:0]             segDec;
    logic [7:0]             segLit;
    logic                   dark;

    // Scan sequencing: the digit index advances when the dwell counter wraps,
    // and returns to 0 after the last digit rather than at a power of two.
    // The frame boundary latches the shadows and bumps the blink frame counter;
    // frameHit_q remembers that edge so o_frame lines up with idx 0 / dwell 0.
    always_comb begin
        dwellEnd   = &dwell_q;
        lastDigit  = (idx_q == IDX_W'(DIGITS - 1));
        boundary   = dwellEnd & lastDigit;

        dwell_d    = dwell_q + 1'b1;
        idx_d      = idx_q;
        fcnt_d     = fcnt_q;
        shData_d   = shData_q;
        shDots_d   = shDots_q;
        shLz_d     = shLz_q;
        frameHit_d = boundary;

        if (dwellEnd) begin
            idx_d = lastDigit ? '0 : idx_q + 1'b1;
        end
        if (boundary) begin
            fcnt_d   = fcnt_q + 1'b1;
            shData_d = i_data;
            shDots_d = i_dots;
            shLz_d   = i_lz_blank;
        end
    end

    // Select the current digit's fields and work out leading-zero blanking.
    // allZero accumulates from the most significant digit downward, so
    // lzMask[k] is set when digit k and every digit above it are zero.
    always_comb begin
        curNib   = 4'h0;
        curDot   = 1'b0;
        curBlink = 1'b0;
        oneHot   = '0;
        lzMask   = '0;
        allZero  = shLz_q;

        for (int k = DIGITS - 1; k >= 0; k--) begin
            allZero   = allZero & (shData_q[4*k +: 4] == 4'h0);
            lzMask[k] = allZero & (k != 0);
            if (idx_q == IDX_W'(k)) begin
                curNib    = shData_q[4*k +: 4];
                curDot    = shDots_q[k];
                curBlink  = i_blink[k];
                oneHot[k] = 1'b1;
            end
        end
        curLzBlank = |(lzMask & oneHot);
    end

    // Hex to segment decode (lit = 1, order ABCDEFG), gating and polarity.
    // The top four dwell bits form the PWM phase compared against brightness.
    always_comb begin
        case (curNib)
            4'h0:    segDec = 7'b1111110;
            4'h1:    segDec = 7'b0110000;
            4'h2:    segDec = 7'b1101101;
            4'h3:    segDec = 7'b1111001;
            4'h4:    segDec = 7'b0110011;
            4'h5:    segDec = 7'b1011011;
            4'h6:    segDec = 7'b1011111;
            4'h7:    segDec = 7'b1110000;
            4'h8:    segDec = 7'b1111111;
            4'h9:    segDec = 7'b1111011;
            4'hA:    segDec = 7'b1110111;
            4'hB:    segDec = 7'b0011111;
            4'hC:    segDec = 7'b1001110;
            4'hD:    segDec = 7'b0111101;
            4'hE:    segDec = 7'b1001111;
            default: segDec = 7'b1000111;
        endcase

        segLit = {curLzBlank ? 7'b0000000 : segDec, curDot};

        dark = ~i_en
             | (dwell_q[CNT_WIDTH-1 -: 4] > i_bright)
             | (curBlink & fcnt_q[BLINK_WIDTH-1]);

        anodes_d   = (dark ? {DIGITS{1'b0}} : oneHot) ^ ANODE_INV;
        segments_d = (dark ? 8'h00 : segLit) ^ SEG_INV;
        frame_d    = frameHit_q;
    end

    // All state and the output registers; reset forces the display dark.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dwell_q    <= '0;
            idx_q      <= '0;
            fcnt_q     <= '0;
            shData_q   <= '0;
            shDots_q   <= '0;
            shLz_q     <= 1'b0;
            frameHit_q <= 1'b0;
            anodes_q   <= ANODE_INV;
            segments_q <= SEG_INV;
            frame_q    <= 1'b0;
        end else begin
            dwell_q    <= dwell_d;
            idx_q      <= idx_d;
            fcnt_q     <= fcnt_d;
            shData_q   <= shData_d;
            shDots_q   <= shDots_d;
            shLz_q     <= shLz_d;
            frameHit_q <= frameHit_d;
            anodes_q   <= anodes_d;
            segments_q <= segments_d;
            frame_q    <= frame_d;
        end
    end

    assign o_anodes   = anodes_q;
    assign o_segments = segments_q;
    assign o_frame    = frame_q;

endmodule

// File: tb/tb_seg7_scanner.sv
// tb_seg7_scanner
// Self-checking bench for seg7_scanner. Two instances run side by side:
// dutA is 4 digits, active-low anodes, active-high segments; dutB is 3 digits
// with the opposite polarities. Both use a 32-cycle dwell and a 2-bit frame
// counter. A cycle-count based reference model predicts every output.

module tb_seg7_scanner;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;

    logic [15:0] dataA;
    logic [3:0]  dotsA, blinkA, brightA;
    logic        lzA, enA;
    logic [3:0]  anA;
    logic [7:0]  segA;
    logic        frA;

    logic [11:0] dataB;
    logic [2:0]  dotsB, blinkB;
    logic [3:0]  brightB;
    logic        lzB, enB;
    logic [2:0]  anB;
    logic [7:0]  segB;
    logic        frB;

    int total = 0;
    int bad   = 0;

    seg7_scanner #(
        .DIGITS(4), .CNT_WIDTH(5), .BLINK_WIDTH(2),
        .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(0)
    ) dutA (
        .clk(clk), .rst_n(rst_n),
        .i_data(dataA), .i_dots(dotsA), .i_lz_blank(lzA), .i_bright(brightA),
        .i_blink(blinkA), .i_en(enA),
        .o_anodes(anA), .o_segments(segA), .o_frame(frA)
    );

    seg7_scanner #(
        .DIGITS(3), .CNT_WIDTH(5), .BLINK_WIDTH(2),
        .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(1)
    ) dutB (
        .clk(clk), .rst_n(rst_n),
        .i_data(dataB), .i_dots(dotsB), .i_lz_blank(lzB), .i_bright(brightB),
        .i_blink(blinkB), .i_en(enB),
        .o_anodes(anB), .o_segments(segB), .o_frame(frB)
    );

    // Reference glyph table, lit = 1, order ABCDEFG.
    function automatic logic [6:0] hexLit(input int n);
        case (n)
            0:  return 7'b1111110;
            1:  return 7'b0110000;
            2:  return 7'b1101101;
            3:  return 7'b1111001;
            4:  return 7'b0110011;
            5:  return 7'b1011011;
            6:  return 7'b1011111;
            7:  return 7'b1110000;
            8:  return 7'b1111111;
            9:  return 7'b1111011;
            10: return 7'b1110111;
            11: return 7'b0011111;
            12: return 7'b1001110;
            13: return 7'b0111101;
            14: return 7'b1001111;
            default: return 7'b1000111;
        endcase
    endfunction

    // Outputs for the state reached c cycles after reset, from plain arithmetic.
    function automatic void modelOut(
        input longint c, input int digits, input int cw, input int bw,
        input logic [63:0] sh, input logic [15:0] dots, input logic lz,
        input logic en, input logic [3:0] bright, input logic [15:0] blink,
        input int aal, input int sal,
        output logic [15:0] an, output logic [7:0] seg);
        longint dw, fc;
        int idx;
        logic [63:0] upper;
        logic lzb, dark;
        dw    = c % (longint'(1) << cw);
        idx   = int'((c >> cw) % digits);
        fc    = (c / (digits * (longint'(1) << cw))) % (longint'(1) << bw);
        upper = sh >> (4 * idx);
        lzb   = lz && (idx >= 1) && (upper == 64'd0);
        dark  = !en || ((dw >> (cw - 4)) > bright) ||
                (blink[idx] && (fc >= (longint'(1) << (bw - 1))));
        an  = 16'd0;
        seg = 8'd0;
        if (!dark) begin
            an[idx] = 1'b1;
            seg = {lzb ? 7'd0 : hexLit(int'(upper[3:0])), dots[idx]};
        end
        if (aal != 0) an = ~an & ((16'd1 << digits) - 16'd1);
        if (sal != 0) seg = ~seg;
    endfunction

    longint      cA, cB;
    logic [15:0] mShA, mDotsA;
    logic [11:0] mShB;
    logic [2:0]  mDotsB;
    logic        mLzA, mLzB;
    logic [3:0]  expAnA;
    logic [7:0]  expSegA;
    logic        expFrA;
    logic [2:0]  expAnB;
    logic [7:0]  expSegB;
    logic        expFrB;
    logic [15:0] tAnA, tAnB;
    logic [7:0]  tSegA, tSegB;

    // Model for dutA: frame = 128 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cA = 0; mShA = 0; mDotsA = 0; mLzA = 0;
            expAnA = 4'hF; expSegA = 8'h00; expFrA = 1'b0;
        end else begin
            modelOut(cA, 4, 5, 2, {48'd0, mShA}, mDotsA, mLzA, enA, brightA,
                     {12'd0, blinkA}, 1, 0, tAnA, tSegA);
            expAnA  = tAnA[3:0];
            expSegA = tSegA;
            expFrA  = (cA > 0) && (cA % 128 == 0);
            if (cA % 128 == 127) begin
                mShA = dataA; mDotsA = {12'd0, dotsA}; mLzA = lzA;
            end
            cA++;
        end
    end

    // Model for dutB: frame = 96 cycles.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cB = 0; mShB = 0; mDotsB = 0; mLzB = 0;
            expAnB = 3'b000; expSegB = 8'hFF; expFrB = 1'b0;
        end else begin
            modelOut(cB, 3, 5, 2, {52'd0, mShB}, {13'd0, mDotsB}, mLzB, enB,
                     brightB, {13'd0, blinkB}, 0, 1, tAnB, tSegB);
            expAnB  = tAnB[2:0];
            expSegB = tSegB;
            expFrB  = (cB > 0) && (cB % 96 == 0);
            if (cB % 96 == 95) begin
                mShB = dataB; mDotsB = dotsB; mLzB = lzB;
            end
            cB++;
        end
    end

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] dots,
                                 input logic lz, input logic [3:0] br,
                                 input logic [3:0] bl, input logic en);
        dataA = d; dotsA = dots; lzA = lz; brightA = br; blinkA = bl; enA = en;
    endtask

    // Returns at the negedge showing a dutA frame pulse at least two edges
    // after the call, so inputs set just before are in that frame's shadow.
    task automatic waitFrameA(output bit ok);
        ok = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clk);
            if (frA === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic waitFrameB(output bit ok);
        ok = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            if (frB === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        applyStimulus(16'h12AF, 4'b0100, 1'b0, 4'd15, 4'b0000, 1'b1);
        dataB = 12'h008; dotsB = 3'b000; lzB = 1'b0; brightB = 4'd15;
        blinkB = 3'b000; enB = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (anA !== 4'hF || segA !== 8'h00 || frA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_A got an=%b seg=%b fr=%b want an=1111 seg=00000000 fr=0", anA, segA, frA);
        end
        total++;
        if (anB !== 3'b000 || segB !== 8'hFF || frB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_B got an=%b seg=%b fr=%b want an=000 seg=11111111 fr=0", anB, segB, frB);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_scan;
        logic [3:0] wantAn [4];
        logic [7:0] wantSeg [4];
        wantAn  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        wantSeg = '{8'b10001110, 8'b11101110, 8'b11011011, 8'b01100000};
        // First frame after reset runs on zeroed shadows.
        for (int i = 0; i < 128; i++) begin
            @(negedge clk);
            total++;
            if (anA !== expAnA || segA !== expSegA || frA !== expFrA) begin
                bad++;
                $display("[TB] FAIL scan_first got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b", anA, segA, frA, expAnA, expSegA, expFrA);
            end
            if (i == 0) begin
                total++;
                if (anA !== 4'b1110 || segA !== 8'b11111100 || frA !== 1'b0) begin
                    bad++;
                    $display("[TB] FAIL scan_after_reset got an=%b seg=%b fr=%b want an=1110 seg=11111100 fr=0", anA, segA, frA);
                end
            end
        end
        // Second frame shows 12AF with a dot on digit 2.
        for (int i = 0; i < 129; i++) begin
            @(negedge clk);
            total++;
            if (anA !== expAnA || segA !== expSegA || frA !== expFrA) begin
                bad++;
                $display("[TB] FAIL scan_model got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b", anA, segA, frA, expAnA, expSegA, expFrA);
            end
            if (i % 32 == 0 && i < 128) begin
                total++;
                if (anA !== wantAn[i/32] || segA !== wantSeg[i/32]) begin
                    bad++;
                    $display("[TB] FAIL scan_digit%0d got an=%b seg=%b want an=%b seg=%b", i/32, anA, segA, wantAn[i/32], wantSeg[i/32]);
                end
            end
            if (i == 0 || i == 128) begin
                total++;
                if (frA !== 1'b1) begin
                    bad++;
                    $display("[TB] FAIL scan_frame_pulse cycle=%0d got=%b want=1", i, frA);
                end
            end
        end
    endtask

    task automatic test_mid_change;
        bit ok;
        applyStimulus(16'h1234, 4'b0000, 1'b0, 4'd15, 4'b0000, 1'b1);
        waitFrameA(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL mid_wait got=no_frame want=frame");
        end
        for (int i = 0; i < 129; i++) begin
            if (i != 0) @(negedge clk);
            if (i == 10) dataA = 16'h5678;
            total++;
            if (anA !== expAnA || segA !== expSegA || frA !== expFrA) begin
                bad++;
                $display("[TB] FAIL mid_model got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b", anA, segA, frA, expAnA, expSegA, expFrA);
            end
            if (i == 0 || i == 96 || i == 128) begin
                total++;
                if (segA !== (i == 0 ? 8'b01100110 : (i == 96 ? 8'b01100000 : 8'b11111110))) begin
                    bad++;
                    $display("[TB] FAIL mid_digit cycle=%0d got seg=%b want seg=%b", i, segA, (i == 0 ? 8'b01100110 : (i == 96 ? 8'b01100000 : 8'b11111110)));
                end
            end
        end
    endtask

    task automatic test_lz;
        bit ok;
        logic [3:0] wantAn [4];
        logic [7:0] wantSeg [4];
        wantAn  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        wantSeg = '{8'b11111100, 8'b11100000, 8'b00000000, 8'b00000001};
        applyStimulus(16'h0070, 4'b1000, 1'b1, 4'd15, 4'b0000, 1'b1);
        waitFrameA(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL lz_wait got=no_frame want=frame");
        end
        for (int i = 0; i < 128; i++) begin
            if (i != 0) @(negedge clk);
            total++;
            if (anA !== expAnA || segA !== expSegA || frA !== expFrA) begin
                bad++;
                $display("[TB] FAIL lz_model got an=%b seg=%b want an=%b seg=%b", anA, segA, expAnA, expSegA);
            end
            if (i % 32 == 5) begin
                total++;
                if (anA !== wantAn[i/32] || segA !== wantSeg[i/32]) begin
                    bad++;
                    $display("[TB] FAIL lz_digit%0d got an=%b seg=%b want an=%b seg=%b", i/32, anA, segA, wantAn[i/32], wantSeg[i/32]);
                end
            end
        end
    endtask

    task automatic test_bright;
        bit ok;
        logic lit;
        int litCnt;
        int b;
        applyStimulus(16'h3C5A, 4'b0000, 1'b0, 4'd3, 4'b0000, 1'b1);
        waitFrameA(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL bright_wait got=no_frame want=frame");
        end
        for (int i = 0; i < 128; i++) begin
            if (i != 0) @(negedge clk);
            lit = (anA !== 4'hF);
            total++;
            if (lit !== ((i % 32) < 8) || anA !== expAnA || segA !== expSegA) begin
                bad++;
                $display("[TB] FAIL bright3_window cycle=%0d got an=%b seg=%b want an=%b seg=%b", i, anA, segA, expAnA, expSegA);
            end
        end
        for (int r = 0; r < 2; r++) begin
            b = $urandom_range(0, 15);
            brightA = 4'(b);
            waitFrameA(ok);
            litCnt = 0;
            for (int i = 0; i < 128; i++) begin
                if (i != 0) @(negedge clk);
                if (anA !== 4'hF) litCnt++;
                total++;
                if (anA !== expAnA || segA !== expSegA) begin
                    bad++;
                    $display("[TB] FAIL bright_model got an=%b seg=%b want an=%b seg=%b", anA, segA, expAnA, expSegA);
                end
            end
            total++;
            if (!ok || litCnt != 8 * (b + 1)) begin
                bad++;
                $display("[TB] FAIL bright_count level=%0d got=%0d want=%0d", b, litCnt, 8 * (b + 1));
            end
        end
    endtask

    task automatic test_enable;
        applyStimulus(16'h8888, 4'b1111, 1'b0, 4'd15, 4'b0000, 1'b0);
        for (int i = 0; i < 70; i++) begin
            @(negedge clk);
            total++;
            if (anA !== 4'hF || segA !== 8'h00 || anA !== expAnA || segA !== expSegA) begin
                bad++;
                $display("[TB] FAIL enable_dark got an=%b seg=%b want an=1111 seg=00000000", anA, segA);
            end
        end
        enA = 1'b1;
        @(negedge clk);
        total++;
        if (anA !== expAnA || segA !== expSegA || anA === 4'hF) begin
            bad++;
            $display("[TB] FAIL enable_back got an=%b seg=%b want an=%b seg=%b", anA, segA, expAnA, expSegA);
        end
    endtask

    task automatic test_blink;
        bit ok;
        int lit0;
        longint fc;
        applyStimulus(16'h4321, 4'b0000, 1'b0, 4'd15, 4'b0001, 1'b1);
        for (int f = 0; f < 5; f++) begin
            waitFrameA(ok);
            fc = ((cA - 1) / 128) % 4;
            lit0 = 0;
            for (int i = 0; i < 128; i++) begin
                if (i != 0) @(negedge clk);
                if (anA === 4'b1110) lit0++;
                total++;
                if (anA !== expAnA || segA !== expSegA) begin
                    bad++;
                    $display("[TB] FAIL blink_model got an=%b seg=%b want an=%b seg=%b", anA, segA, expAnA, expSegA);
                end
            end
            total++;
            if (!ok || lit0 != (fc >= 2 ? 0 : 32)) begin
                bad++;
                $display("[TB] FAIL blink_digit0 fcnt=%0d got=%0d want=%0d", fc, lit0, (fc >= 2 ? 0 : 32));
            end
        end
    endtask

    task automatic test_random;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            total++;
            if (anA !== expAnA || segA !== expSegA || frA !== expFrA) begin
                bad++;
                $display("[TB] FAIL random_A got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b", anA, segA, frA, expAnA, expSegA, expFrA);
            end
            total++;
            if (anB !== expAnB || segB !== expSegB || frB !== expFrB) begin
                bad++;
                $display("[TB] FAIL random_B got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b", anB, segB, frB, expAnB, expSegB, expFrB);
            end
            if ($urandom_range(0, 5) == 0) begin
                applyStimulus(16'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom),
                              4'($urandom), 1'($urandom), 4'($urandom), 4'($urandom),
                              ($urandom_range(0, 7) != 0));
                dataB   = 12'($urandom_range(0, 1) == 0 ? $urandom_range(0, 15) : $urandom);
                dotsB   = 3'($urandom);
                lzB     = 1'($urandom);
                brightB = 4'($urandom);
                blinkB  = 3'($urandom);
                enB     = ($urandom_range(0, 7) != 0);
            end
        end
    endtask

    task automatic test_dut_b;
        bit ok;
        logic [2:0] wantAn [4];
        logic [7:0] wantSeg [4];
        wantAn  = '{3'b001, 3'b010, 3'b100, 3'b001};
        wantSeg = '{8'b00000001, 8'b00000011, 8'b00000011, 8'b00000001};
        dataB = 12'h008; dotsB = 3'b000; lzB = 1'b0; brightB = 4'd15;
        blinkB = 3'b000; enB = 1'b1;
        waitFrameB(ok);
        total++;
        if (!ok) begin
            bad++;
            $display("[TB] FAIL b_wait got=no_frame want=frame");
        end
        for (int i = 0; i < 97; i++) begin
            if (i != 0) @(negedge clk);
            total++;
            if (anB !== expAnB || segB !== expSegB || frB !== expFrB ||
                !(anB == 3'b001 || anB == 3'b010 || anB == 3'b100)) begin
                bad++;
                $display("[TB] FAIL b_model got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b", anB, segB, frB, expAnB, expSegB, expFrB);
            end
            if (i % 32 == 0) begin
                total++;
                if (anB !== wantAn[i/32] || segB !== wantSeg[i/32] || frB !== (i == 0 || i == 96)) begin
                    bad++;
                    $display("[TB] FAIL b_digit cycle=%0d got an=%b seg=%b fr=%b want an=%b seg=%b", i, anB, segB, frB, wantAn[i/32], wantSeg[i/32]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        applyStimulus(16'h9ABC, 4'b0000, 1'b0, 4'd15, 4'b0000, 1'b1);
        repeat (45) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (anA !== 4'hF || segA !== 8'h00 || frA !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_A got an=%b seg=%b fr=%b want an=1111 seg=00000000 fr=0", anA, segA, frA);
        end
        total++;
        if (anB !== 3'b000 || segB !== 8'hFF || frB !== 1'b0) begin
            bad++;
            $display("[TB] FAIL reset_mid_B got an=%b seg=%b fr=%b want an=000 seg=11111111 fr=0", anB, segB, frB);
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            total++;
            if (anA !== expAnA || segA !== expSegA || frA !== expFrA) begin
                bad++;
                $display("[TB] FAIL reset_restart got an=%b seg=%b fr=%b want an=%b seg=%b fr=%b", anA, segA, frA, expAnA, expSegA, expFrA);
            end
            if (i == 0) begin
                total++;
                if (anA !== 4'b1110 || segA !== 8'b11111100) begin
                    bad++;
                    $display("[TB] FAIL reset_restart_digit0 got an=%b seg=%b want an=1110 seg=11111100", anA, segA);
                end
            end
        end
    endtask

    initial begin
        test_reset;
        test_scan;
        test_mid_change;
        test_lz;
        test_bright;
        test_enable;
        test_blink;
        test_random;
        test_dut_b;
        test_reset_mid;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
